// File: rtl/ptp_pkg.sv
// Shared constants and the trigger state encoding for PTP time consumers.
package ptp_pkg;

  localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;
  localparam logic [31:0] NS_MAX     = 32'd999_999_999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRE  = 2'd2
  } trig_state_e;

endpackage

// File: rtl/ptp_time_add.sv
// Combinational {sec,ns} + nanosecond-period adder with the one-second wrap.
module ptp_time_add
  import ptp_pkg::*;
(
  input  logic [47:0] sec_in,
  input  logic [31:0] ns_in,
  input  logic [29:0] period_ns,
  output logic [47:0] sec_out,
  output logic [31:0] ns_out
);

  logic [32:0] ns_sum;

  // Inputs are at most NS_MAX each, so at most one second can carry out.
  always_comb begin
    ns_sum = {1'b0, ns_in} + {3'b000, period_ns};
    if (ns_sum >= {1'b0, NS_PER_SEC}) begin
      ns_out  = 32'(ns_sum - {1'b0, NS_PER_SEC});
      sec_out = sec_in + 48'd1;
    end else begin
      ns_out  = ns_sum[31:0];
      sec_out = sec_in;
    end
  end

endmodule

// File: rtl/ptp_tgt_trig.sv
// Target-time trigger: pulses trig_out when the live PTP time reaches a loaded target.
// Define PTP_TGT_TRIG_TS_CAPTURE_EN to build the fire-time capture registers.
module ptp_tgt_trig
  import ptp_pkg::*;
#(
  parameter int PW_BITS  = 24,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         time_ptp_ns,
  input  logic [47:0]         time_ptp_sec,
  input  logic                tgt_ld,
  input  logic [31:0]         tgt_ns_in,
  input  logic [47:0]         tgt_sec_in,
  input  logic [29:0]         period_ns_in,
  input  logic [PW_BITS-1:0]  pulse_w_in,
  input  logic                arm,
  input  logic                disarm,
  input  logic                err_clr,
  output logic                trig_out,
  output logic                armed_out,
  output logic                err_late_out,
  output logic                err_cfg_out,
  output logic [CNT_BITS-1:0] fire_cnt_out,
  output logic [31:0]         fire_ns_out,
  output logic [47:0]         fire_sec_out
);

  trig_state_e         state_q, state_d;
  logic [47:0]         tgt_sec_q, tgt_sec_d, adv_sec;
  logic [31:0]         tgt_ns_q, tgt_ns_d, adv_ns;
  logic [29:0]         period_q, period_d;
  logic [PW_BITS-1:0]  pulse_w_q, pulse_w_d, width_cnt_q, width_cnt_d;
  logic                first_cmp_q, first_cmp_d;
  logic                reached_q, reached_d;
  logic                err_late_q, err_late_d, err_cfg_q, err_cfg_d;
  logic [CNT_BITS-1:0] fire_cnt_q, fire_cnt_d;
  logic                fire, late_set, cfg_set;

  ptp_time_add u_advance (
    .sec_in    (tgt_sec_q),
    .ns_in     (tgt_ns_q),
    .period_ns (period_q),
    .sec_out   (adv_sec),
    .ns_out    (adv_ns)
  );

  assign reached_d = {time_ptp_sec, time_ptp_ns} >= {tgt_sec_q, tgt_ns_q};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    tgt_sec_d   = tgt_sec_q;
    tgt_ns_d    = tgt_ns_q;
    period_d    = period_q;
    pulse_w_d   = pulse_w_q;
    first_cmp_d = first_cmp_q;
    width_cnt_d = width_cnt_q;
    fire        = 1'b0;
    late_set    = 1'b0;
    cfg_set     = 1'b0;

    if (state_q == IDLE && tgt_ld) begin
      if (tgt_ns_in > NS_MAX || {2'b00, period_ns_in} > NS_MAX) begin
        cfg_set = 1'b1;
      end else begin
        tgt_sec_d = tgt_sec_in;
        tgt_ns_d  = tgt_ns_in;
        period_d  = period_ns_in;
        pulse_w_d = pulse_w_in;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (arm && !disarm) begin
          state_d     = ARMED;
          first_cmp_d = 1'b1;
        end
      end
      ARMED: begin
        first_cmp_d = 1'b0;
        if (disarm) begin
          state_d = IDLE;
        end else if (reached_q) begin
          // A target already behind us on the first compare is an error, not a fire.
          if (first_cmp_q) begin
            late_set = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d     = FIRE;
            fire        = 1'b1;
            width_cnt_d = (pulse_w_q == '0) ? PW_BITS'(1) : pulse_w_q;
            if (period_q != '0) begin
              tgt_sec_d = adv_sec;
              tgt_ns_d  = adv_ns;
            end
          end
        end
      end
      FIRE: begin
        if (disarm) begin
          state_d = IDLE;
        end else if (width_cnt_q <= PW_BITS'(1)) begin
          state_d     = (period_q == '0) ? IDLE : ARMED;
          first_cmp_d = (period_q != '0);
        end else begin
          width_cnt_d = width_cnt_q - PW_BITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    err_late_d = late_set | (err_late_q & ~err_clr);
    err_cfg_d  = cfg_set  | (err_cfg_q  & ~err_clr);
    fire_cnt_d = fire ? fire_cnt_q + CNT_BITS'(1) : fire_cnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tgt_sec_q   <= '0;
      tgt_ns_q    <= '0;
      period_q    <= '0;
      pulse_w_q   <= '0;
      width_cnt_q <= '0;
      first_cmp_q <= 1'b0;
      reached_q   <= 1'b0;
      err_late_q  <= 1'b0;
      err_cfg_q   <= 1'b0;
      fire_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      tgt_sec_q   <= tgt_sec_d;
      tgt_ns_q    <= tgt_ns_d;
      period_q    <= period_d;
      pulse_w_q   <= pulse_w_d;
      width_cnt_q <= width_cnt_d;
      first_cmp_q <= first_cmp_d;
      reached_q   <= reached_d;
      err_late_q  <= err_late_d;
      err_cfg_q   <= err_cfg_d;
      fire_cnt_q  <= fire_cnt_d;
    end
  end

  assign trig_out     = (state_q == FIRE);
  assign armed_out    = (state_q != IDLE);
  assign err_late_out = err_late_q;
  assign err_cfg_out  = err_cfg_q;
  assign fire_cnt_out = fire_cnt_q;

`ifdef PTP_TGT_TRIG_TS_CAPTURE_EN
  // The delay stage aligns the captured time with the one that set reached_q.
  logic [31:0] dly_ns_q, fire_ns_q, fire_ns_d;
  logic [47:0] dly_sec_q, fire_sec_q, fire_sec_d;

  always_comb begin
    fire_ns_d  = fire ? dly_ns_q  : fire_ns_q;
    fire_sec_d = fire ? dly_sec_q : fire_sec_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dly_ns_q   <= '0;
      dly_sec_q  <= '0;
      fire_ns_q  <= '0;
      fire_sec_q <= '0;
    end else begin
      dly_ns_q   <= time_ptp_ns;
      dly_sec_q  <= time_ptp_sec;
      fire_ns_q  <= fire_ns_d;
      fire_sec_q <= fire_sec_d;
    end
  end

  assign fire_ns_out  = fire_ns_q;
  assign fire_sec_out = fire_sec_q;
`else
  assign fire_ns_out  = '0;
  assign fire_sec_out = '0;
`endif

endmodule

// File: tb/tb_ptp_tgt_trig.sv
// Self-checking bench for ptp_tgt_trig: directed scenarios plus randomized traffic
// checked every cycle against a time-as-total-nanoseconds reference model.
module tb_ptp_tgt_trig;

  localparam int     PW_BITS  = 24;
  localparam int     CNT_BITS = 16;
  localparam longint NS       = 64'd1_000_000_000;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [31:0]         time_ptp_ns;
  logic [47:0]         time_ptp_sec;
  logic                tgt_ld = 1'b0;
  logic [31:0]         tgt_ns_in = '0;
  logic [47:0]         tgt_sec_in = '0;
  logic [29:0]         period_ns_in = '0;
  logic [PW_BITS-1:0]  pulse_w_in = '0;
  logic                arm = 1'b0;
  logic                disarm = 1'b0;
  logic                err_clr = 1'b0;
  logic                trig_out, armed_out, err_late_out, err_cfg_out;
  logic [CNT_BITS-1:0] fire_cnt_out;
  logic [31:0]         fire_ns_out;
  logic [47:0]         fire_sec_out;

  longint cur_t   = 0;
  longint step_ns = 0;

  assign time_ptp_sec = 48'(cur_t / NS);
  assign time_ptp_ns  = 32'(cur_t % NS);

  ptp_tgt_trig #(.PW_BITS(PW_BITS), .CNT_BITS(CNT_BITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .time_ptp_ns  (time_ptp_ns),
    .time_ptp_sec (time_ptp_sec),
    .tgt_ld       (tgt_ld),
    .tgt_ns_in    (tgt_ns_in),
    .tgt_sec_in   (tgt_sec_in),
    .period_ns_in (period_ns_in),
    .pulse_w_in   (pulse_w_in),
    .arm          (arm),
    .disarm       (disarm),
    .err_clr      (err_clr),
    .trig_out     (trig_out),
    .armed_out    (armed_out),
    .err_late_out (err_late_out),
    .err_cfg_out  (err_cfg_out),
    .fire_cnt_out (fire_cnt_out),
    .fire_ns_out  (fire_ns_out),
    .fire_sec_out (fire_sec_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: times are plain total-nanosecond integers.
  int     m_mode;      // 0 idle, 1 waiting for target, 2 pulsing
  longint m_tgt, m_per, m_fire_t, m_prev_t;
  int     m_w, m_left, m_cnt;
  bit     m_prev_hit, m_first, m_late, m_cfg;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    longint t = cur_t;
    bit     hit_now = (t >= m_tgt);
    bit     late_set = 1'b0, cfg_set = 1'b0;
    int     n_mode = m_mode, n_left = m_left, n_cnt = m_cnt, n_w = m_w;
    longint n_tgt = m_tgt, n_per = m_per, n_fire = m_fire_t;
    bit     n_first = m_first;
    if (rst) begin
      m_mode = 0; m_tgt = 0; m_per = 0; m_w = 0; m_left = 0; m_cnt = 0;
      m_prev_hit = 0; m_first = 0; m_late = 0; m_cfg = 0; m_fire_t = 0; m_prev_t = 0;
      return;
    end
    if (m_mode == 0 && tgt_ld) begin
      if (longint'(tgt_ns_in) >= NS || longint'(period_ns_in) >= NS) cfg_set = 1'b1;
      else begin
        n_tgt = longint'(tgt_sec_in) * NS + longint'(tgt_ns_in);
        n_per = longint'(period_ns_in);
        n_w   = int'(pulse_w_in);
      end
    end
    case (m_mode)
      0: if (arm && !disarm) begin n_mode = 1; n_first = 1'b1; end
      1: begin
        n_first = 1'b0;
        if (disarm) n_mode = 0;
        else if (m_prev_hit && m_first) begin late_set = 1'b1; n_mode = 0; end
        else if (m_prev_hit) begin
          n_mode = 2;
          n_left = (m_w == 0) ? 1 : m_w;
          n_cnt  = (m_cnt + 1) % (1 << CNT_BITS);
          n_fire = m_prev_t;
          n_tgt  = m_tgt + m_per;
        end
      end
      default: begin
        if (disarm) n_mode = 0;
        else begin
          n_left = m_left - 1;
          if (n_left == 0) begin
            n_mode  = (m_per != 0) ? 1 : 0;
            n_first = (m_per != 0);
          end
        end
      end
    endcase
    m_late = late_set | (m_late & !err_clr);
    m_cfg  = cfg_set  | (m_cfg  & !err_clr);
    m_mode = n_mode; m_left = n_left; m_cnt = n_cnt; m_w = n_w;
    m_tgt = n_tgt; m_per = n_per; m_fire_t = n_fire; m_first = n_first;
    m_prev_hit = hit_now; m_prev_t = t;
  endtask

  task automatic check_outputs();
    longint exp_fsec = 0, exp_fns = 0;
`ifdef PTP_TGT_TRIG_TS_CAPTURE_EN
    exp_fsec = m_fire_t / NS;
    exp_fns  = m_fire_t % NS;
`endif
    check("trig_out",     64'(trig_out),     64'(m_mode == 2));
    check("armed_out",    64'(armed_out),    64'(m_mode != 0));
    check("err_late_out", 64'(err_late_out), 64'(m_late));
    check("err_cfg_out",  64'(err_cfg_out),  64'(m_cfg));
    check("fire_cnt_out", 64'(fire_cnt_out), 64'(m_cnt));
    check("fire_sec_out", 64'(fire_sec_out), 64'(exp_fsec));
    check("fire_ns_out",  64'(fire_ns_out),  64'(exp_fns));
  endtask

  // One clock: model samples the same inputs as the DUT, outputs checked 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    tgt_ld = 1'b0; arm = 1'b0; disarm = 1'b0; err_clr = 1'b0;
    cur_t += step_ns;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic load(input longint sec, input longint ns, input longint per, input int w);
    tgt_ld = 1'b1; tgt_sec_in = 48'(sec); tgt_ns_in = 32'(ns);
    period_ns_in = 30'(per); pulse_w_in = PW_BITS'(w);
    tick();
  endtask

  initial begin
    int first_hi, hi_cnt;
    longint exp_sec, exp_ns;

    // Reset state
    do_reset();
    check("rst_trig", 64'(trig_out), 64'd0);
    check("rst_cnt",  64'(fire_cnt_out), 64'd0);
    check("rst_fsec", 64'(fire_sec_out), 64'd0);

    // One-shot fire at 5/100, width 3, time sweeping 8 ns per clock from 5/90
    load(5, 100, 0, 3);
    cur_t = 5 * NS + 90; step_ns = 8; arm = 1'b1;
    first_hi = -1; hi_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (trig_out && first_hi < 0) first_hi = k;
      if (trig_out) hi_cnt++;
    end
    check("os_rise_cycle", 64'(first_hi), 64'd3);
    check("os_width",      64'(hi_cnt),   64'd3);
    check("os_cnt",        64'(fire_cnt_out), 64'd1);
    check("os_idle",       64'(armed_out), 64'd0);

    // Periodic with nanosecond wrap: 7/999_999_990 then 8/10
    do_reset();
    load(7, 999_999_990, 20, 1);
    cur_t = 7 * NS + 999_999_970; step_ns = 4; arm = 1'b1;
    for (int k = 0; k < 40 && fire_cnt_out != 2; k++) tick();
    check("per_two_fires", 64'(fire_cnt_out), 64'd2);
    exp_sec = 0; exp_ns = 0;
`ifdef PTP_TGT_TRIG_TS_CAPTURE_EN
    exp_sec = 8; exp_ns = 10;
`endif
    check("per_fire_sec", 64'(fire_sec_out), 64'(exp_sec));
    check("per_fire_ns",  64'(fire_ns_out),  64'(exp_ns));
    check("per_no_late",  64'(err_late_out), 64'd0);
    disarm = 1'b1; tick(); tick();
    check("per_disarmed", 64'(armed_out), 64'd0);

    // Late arm: live 10/0, target 9/500
    do_reset();
    load(9, 500, 0, 1);
    cur_t = 10 * NS; step_ns = 0; arm = 1'b1;
    hi_cnt = 0;
    for (int k = 0; k < 4; k++) begin tick(); if (trig_out) hi_cnt++; end
    check("late_flag",  64'(err_late_out), 64'd1);
    check("late_armed", 64'(armed_out), 64'd0);
    check("late_nopul", 64'(hi_cnt), 64'd0);
    err_clr = 1'b1; tick();
    check("late_clr", 64'(err_late_out), 64'd0);

    // Config reject keeps 9/500; a load while armed is ignored
    load(3, 0, 1_000_000_000, 2);
    check("cfg_flag", 64'(err_cfg_out), 64'd1);
    cur_t = 9 * NS + 400; step_ns = 20; arm = 1'b1; tick();
    tgt_ld = 1'b1; tgt_sec_in = 48'd20; tgt_ns_in = 32'd0; period_ns_in = '0; tick();
    for (int k = 0; k < 20 && fire_cnt_out != 1; k++) tick();
    check("cfg_kept_tgt", 64'(fire_cnt_out), 64'd1);
    check("cfg_no_late",  64'(err_late_out), 64'd0);
    check("cfg_sticky",   64'(err_cfg_out),  64'd1);

    // Disarm racing the first registered reach
    do_reset();
    load(12, 0, 0, 2);
    cur_t = 11 * NS + 999_999_990; step_ns = 10; arm = 1'b1; tick();
    tick();
    disarm = 1'b1; tick();
    check("race_trig",  64'(trig_out),  64'd0);
    check("race_armed", 64'(armed_out), 64'd0);
    for (int k = 0; k < 3; k++) tick();
    check("race_cnt", 64'(fire_cnt_out), 64'd0);

    // Arm during FIRE has no effect
    load(13, 0, 0, 4);
    cur_t = 12 * NS + 999_999_990; step_ns = 10; arm = 1'b1;
    for (int k = 0; k < 10 && !trig_out; k++) tick();
    check("fire_seen", 64'(trig_out), 64'd1);
    arm = 1'b1; tick();
    for (int k = 0; k < 6; k++) tick();
    check("arm_in_fire_cnt",  64'(fire_cnt_out), 64'd1);
    check("arm_in_fire_idle", 64'(armed_out), 64'd0);

    // Reset in the 2nd cycle of a 5-cycle pulse
    do_reset();
    load(14, 0, 0, 5);
    cur_t = 13 * NS + 999_999_990; step_ns = 10; arm = 1'b1;
    for (int k = 0; k < 10 && !trig_out; k++) tick();
    check("rp_fire", 64'(trig_out), 64'd1);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("rp_trig",  64'(trig_out), 64'd0);
    check("rp_armed", 64'(armed_out), 64'd0);
    check("rp_cnt",   64'(fire_cnt_out), 64'd0);

    // Randomized traffic near the live time
    do_reset();
    cur_t = 20 * NS + longint'($urandom_range(0, 999_999_000));
    for (int k = 0; k < 800; k++) begin
      longint t;
      step_ns = longint'($urandom_range(0, 16));
      if ($urandom_range(0, 60) == 0) cur_t = 20 * NS + longint'($urandom_range(0, 1_999_999_000));
      if ($urandom_range(0, 5) == 0) begin
        t = cur_t + longint'($urandom_range(0, 400)) - 100;
        tgt_ld = 1'b1;
        tgt_sec_in = 48'(t / NS);
        tgt_ns_in = ($urandom_range(0, 12) == 0) ? 32'(NS) + 32'($urandom_range(0, 3)) : 32'(t % NS);
        period_ns_in = ($urandom_range(0, 12) == 0) ? 30'(NS) : 30'($urandom_range(0, 3) * $urandom_range(0, 60));
        pulse_w_in = PW_BITS'($urandom_range(0, 4));
      end
      arm     = ($urandom_range(0, 6) == 0);
      disarm  = ($urandom_range(0, 40) == 0);
      err_clr = ($urandom_range(0, 25) == 0);
      rst     = ($urandom_range(0, 200) == 0);
      tick();
      rst = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
